// File: rtl/reg_file_pkg.sv
// Shared pipeline package: default register-file geometry used by decode,
// write-back and the register file itself.
//   ADDR_LEN_DEF  - register address width (2**ADDR_LEN_DEF registers)
//   WORD_SIZE_DEF - register data width
package reg_file_pkg;

    localparam int unsigned ADDR_LEN_DEF  = 5;
    localparam int unsigned WORD_SIZE_DEF = 32;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   w_en_i         - write-back strobe
//   dst_addr_i     - write-back destination (clears its busy bit)
//   issue_en_i     - decode issues an instruction writing issue_addr_i
//   issue_addr_i   - destination of the issued instruction (sets busy)
//   rs1_addr_i     - read source 1
//   rs2_addr_i     - read source 2
//   stall_o        - a source is busy and not covered by the bypass
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en_i,
    input  logic [ADDR_LEN-1:0] dst_addr_i,
    input  logic                issue_en_i,
    input  logic [ADDR_LEN-1:0] issue_addr_i,
    input  logic [ADDR_LEN-1:0] rs1_addr_i,
    input  logic [ADDR_LEN-1:0] rs2_addr_i,
    output logic                stall_o
);

    localparam int unsigned NREG = 2 ** ADDR_LEN;

    logic [NREG-1:0] busy_q, busy_d;
    logic            rs1_busy, rs2_busy;

    // The issue update is applied after the write-back clear so that an
    // issue and a write-back to the same register leave it busy.
    always_comb begin
        busy_d = busy_q;
        if (w_en_i)
            busy_d[dst_addr_i] = 1'b0;
        if (issue_en_i && issue_addr_i != '0)
            busy_d[issue_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    // A source being written back this cycle is served by the bypass.
    always_comb begin
        rs1_busy = busy_q[rs1_addr_i] && !(w_en_i && dst_addr_i == rs1_addr_i);
        rs2_busy = busy_q[rs2_addr_i] && !(w_en_i && dst_addr_i == rs2_addr_i);
        stall_o  = !rst && (rs1_busy || rs2_busy);
    end

endmodule

// File: rtl/reg_file.sv
// Register file with write-back bypass and busy-bit scoreboard.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   w_en          - write-back strobe
//   dst_addr_i    - write-back destination register
//   data_i        - write-back data
//   rs1_addr_i    - read port 1 address
//   rs2_addr_i    - read port 2 address
//   rs1_data_o    - read port 1 data (combinational)
//   rs2_data_o    - read port 2 data (combinational)
//   issue_en      - decode issues an instruction that writes issue_addr_i
//   issue_addr_i  - destination register of the issued instruction
//   stall_o       - a read source has a pending result
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_LEN  = ADDR_LEN_DEF,
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en,
    input  logic [ADDR_LEN-1:0]  dst_addr_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic [ADDR_LEN-1:0]  rs1_addr_i,
    input  logic [ADDR_LEN-1:0]  rs2_addr_i,
    output logic [WORD_SIZE-1:0] rs1_data_o,
    output logic [WORD_SIZE-1:0] rs2_data_o,
    input  logic                 issue_en,
    input  logic [ADDR_LEN-1:0]  issue_addr_i,
    output logic                 stall_o
);

    localparam int unsigned NREG = 2 ** ADDR_LEN;

    logic [WORD_SIZE-1:0] regs_q [NREG];
    logic [WORD_SIZE-1:0] regs_d [NREG];

    // Register 0 is never written, so it stays at its reset value of 0.
    always_comb begin
        regs_d = regs_q;
        if (w_en && dst_addr_i != '0)
            regs_d[dst_addr_i] = data_i;
    end

    always_ff @(posedge clk) begin
        if (rst)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    // Bypass takes priority even during reset; otherwise reset forces 0
    // so the ports read clean zeros before the array has been cleared.
    always_comb begin
        if (w_en && rs1_addr_i != '0 && dst_addr_i == rs1_addr_i)
            rs1_data_o = data_i;
        else if (rst)
            rs1_data_o = '0;
        else
            rs1_data_o = regs_q[rs1_addr_i];

        if (w_en && rs2_addr_i != '0 && dst_addr_i == rs2_addr_i)
            rs2_data_o = data_i;
        else if (rst)
            rs2_data_o = '0;
        else
            rs2_data_o = regs_q[rs2_addr_i];
    end

    reg_scoreboard #(
        .ADDR_LEN(ADDR_LEN)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .w_en_i      (w_en),
        .dst_addr_i  (dst_addr_i),
        .issue_en_i  (issue_en),
        .issue_addr_i(issue_addr_i),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .stall_o     (stall_o)
    );

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        w_en;
    logic [4:0]  dst_addr_i;
    logic [31:0] data_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        issue_en;
    logic [4:0]  issue_addr_i;
    logic        stall_o;

    reg_file #(
        .ADDR_LEN (5),
        .WORD_SIZE(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .dst_addr_i  (dst_addr_i),
        .data_i      (data_i),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o),
        .issue_en    (issue_en),
        .issue_addr_i(issue_addr_i),
        .stall_o     (stall_o)
    );

    // Clock starts high: inputs change just after a rising edge, outputs
    // are sampled on the falling edge, state updates on the next rise.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: architectural register values and pending-result set.
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    function automatic logic [31:0] model_read(input logic r, input logic we,
                                                input logic [4:0] d, input logic [31:0] dat,
                                                input logic [4:0] a);
        if (we && a != 0 && d == a) return dat;
        if (r || a == 0) return 32'h0;
        return m_reg[a];
    endfunction

    task automatic drive(input logic r, input logic we, input logic [4:0] d,
                         input logic [31:0] dat, input logic [4:0] a1, input logic [4:0] a2,
                         input logic ie, input logic [4:0] ia, input string nm);
        exp_t e;
        rst = r; w_en = we; dst_addr_i = d; data_i = dat;
        rs1_addr_i = a1; rs2_addr_i = a2; issue_en = ie; issue_addr_i = ia;
        e.r1 = model_read(r, we, d, dat, a1);
        e.r2 = model_read(r, we, d, dat, a2);
        e.st = !r && ((m_busy[a1] && !(we && d == a1)) || (m_busy[a2] && !(we && d == a2)));
        e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && d != 0) m_reg[d] = dat;
            if (we) m_busy[d] = 1'b0;
            if (ie && ia != 0) m_busy[ia] = 1'b1;
        end
        #1;
    endtask

    // Monitor: the DUT output is valid every cycle, so each falling edge
    // retires one expected entry.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (rs1_data_o !== e.r1) begin
                bad++;
                $display("FAIL %s rs1_data: got %h want %h", e.name, rs1_data_o, e.r1);
            end
            total++;
            if (rs2_data_o !== e.r2) begin
                bad++;
                $display("FAIL %s rs2_data: got %h want %h", e.name, rs2_data_o, e.r2);
            end
            total++;
            if (stall_o !== e.st) begin
                bad++;
                $display("FAIL %s stall: got %b want %b", e.name, stall_o, e.st);
            end
        end
    end

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end

        // Reset: clean zeros, then a write-back and issue during reset are dropped.
        drive(1, 0, 0, 0, 1, 2, 0, 0, "rst_idle");
        drive(1, 1, 2, 32'h1111_2222, 1, 3, 1, 4, "rst_wb");
        drive(0, 0, 0, 0, 2, 4, 0, 0, "post_rst");

        // Write then read next cycle.
        drive(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, "wr5");
        drive(0, 0, 0, 0, 5, 0, 0, 0, "rd5");
        // Same-cycle bypass on port 2.
        drive(0, 1, 7, 32'h1234_5678, 5, 7, 0, 0, "byp7");
        // Writes to register 0 are ignored and never bypassed.
        drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, "wr0");
        drive(0, 0, 0, 0, 0, 7, 0, 0, "rd0");
        // Issue then stall, cleared by write-back the same cycle.
        drive(0, 0, 0, 0, 0, 0, 1, 3, "iss3");
        drive(0, 0, 0, 0, 3, 0, 0, 0, "stall3");
        drive(0, 1, 3, 32'h0000_00A5, 3, 0, 0, 0, "wb3");
        drive(0, 0, 0, 0, 3, 3, 0, 0, "rd3");
        // Issue register 0 never marks it busy.
        drive(0, 0, 0, 0, 0, 0, 1, 0, "iss0");
        drive(0, 0, 0, 0, 0, 0, 0, 0, "rd0b");
        // Issue and write-back on the same register: the issue wins.
        drive(0, 1, 9, 32'h0000_0077, 0, 0, 1, 9, "iss_wb9");
        drive(0, 0, 0, 0, 0, 9, 0, 0, "stall9");
        // Registers 1..4 written, 6 busy, then reset clears everything.
        for (int i = 1; i <= 4; i++)
            drive(0, 1, 5'(i), 32'hC0DE_0000 + 32'(i), 0, 0, 0, 0, "fill");
        drive(0, 0, 0, 0, 0, 0, 1, 6, "iss6");
        drive(0, 0, 0, 0, 1, 6, 0, 0, "pre_rst");
        drive(1, 0, 0, 0, 2, 6, 0, 0, "mid_rst");
        drive(0, 0, 0, 0, 1, 6, 0, 0, "after_rst_a");
        drive(0, 0, 0, 0, 3, 4, 0, 0, "after_rst_b");

        // Randomized traffic over a biased address set to exercise hazards.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
                  rnd_addr(), rnd_addr(),
                  1'($urandom_range(0, 1)), rnd_addr(), "rand");
        end

        // Let the monitor drain, bounded.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 5, register-address width (2**ADDR_LEN registers).
REQ-002 SHALL have parameter WORD_SIZE, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port w_en  input  1  write-back strobe from the WB stage.
REQ-006 SHALL have port dst_addr_i  input  ADDR_LEN  write-back destination register.
REQ-007 SHALL have port data_i  input  WORD_SIZE  write-back data.
REQ-008 SHALL have port rs1_addr_i  input  ADDR_LEN  read port 1 address.
REQ-009 SHALL have port rs2_addr_i  input  ADDR_LEN  read port 2 address.
REQ-010 SHALL have port rs1_data_o  output  WORD_SIZE  read port 1 data.
REQ-011 SHALL have port rs2_data_o  output  WORD_SIZE  read port 2 data.
REQ-012 SHALL have port issue_en  input  1  decode issues an instruction that will write issue_addr_i.
REQ-013 SHALL have port issue_addr_i  input  ADDR_LEN  destination register of the issued instruction.
REQ-014 SHALL have port stall_o  output  1  a read source has a pending, not-yet-written result.

Function
REQ-015 SHALL hold 2**ADDR_LEN registers of WORD_SIZE bits, plus one busy bit per register (scoreboard).
REQ-016 SHALL write data_i into register dst_addr_i on a rising clk edge when w_en=1 and rst=0.
REQ-017 SHALL ignore writes to register 0; register 0 SHALL always read 0 and never be marked busy.
REQ-018 SHALL drive read data combinationally, with zero-cycle latency from address change.
REQ-019 SHALL bypass: when w_en=1 and dst_addr_i equals a nonzero read address in the same cycle, that port SHALL output data_i.
REQ-020 SHALL set busy[issue_addr_i] on a rising edge when issue_en=1 and issue_addr_i is nonzero.
REQ-021 SHALL clear busy[dst_addr_i] on a rising edge when w_en=1.
REQ-022 SHALL leave busy set when issue and write-back target the same register in the same cycle (the new issue wins).
REQ-023 SHALL assert stall_o combinationally when busy[rs1_addr_i] or busy[rs2_addr_i] is set.
REQ-024 SHALL NOT assert stall_o for a busy source that is being written back in the same cycle (w_en=1, matching dst_addr_i), because the bypass covers it.
REQ-025 SHALL accept w_en for a register that is not busy: write the data and leave the busy bit clear.
REQ-026 SHALL keep stall_o a pure function of the current state and inputs, with no added cycle of delay.

Reset
REQ-027 SHALL, on a rising edge with rst=1, clear all registers to 0 and all busy bits to 0, overriding w_en and issue_en in that cycle.
REQ-028 SHALL, while rst=1 with no write-back bypass active, read 0 on both read ports and hold stall_o=0.
REQ-029 SHALL drop any write-back pending at the time of a mid-operation reset; the register stays 0.

Structure
REQ-030 SHALL take ADDR_LEN and WORD_SIZE defaults from the shared pipeline package, which WB and decode also use.
REQ-031 SHALL be split into at most one sub-module, reg_scoreboard (busy bits plus stall logic); the storage array SHALL be inline.

Verification
REQ-032 SHALL cover: reset, then w_en=1, dst=5, data=0xDEADBEEF, then rs1=5 on the next cycle -> rs1_data_o=0xDEADBEEF.
REQ-033 SHALL cover: in one cycle w_en=1, dst=7, data=0x12345678, with rs2=7 -> rs2_data_o=0x12345678 in that same cycle (bypass).
REQ-034 SHALL cover: w_en=1, dst=0, data=0xFFFFFFFF, then rs1=0 -> rs1_data_o=0 and stall_o=0.
REQ-035 SHALL cover: issue_en=1, addr=3, then rs1=3 -> stall_o=1; w_en=1 on dst 3 with data 0xA5 -> stall_o=0 that cycle and rs1_data_o=0xA5.
REQ-036 SHALL cover: issue_en=1 and w_en=1, both on register 9, in one cycle -> busy[9] stays 1 and stall_o=1 with rs2=9 on the next cycle.
REQ-037 SHALL cover: registers 1 to 4 written nonzero and register 6 busy, then rst=1 for one cycle -> all reads 0 and stall_o=0 afterwards.
